// File: rtl/instrumentation_pkg.sv
// rtl/instrumentation_pkg.sv - shared constants, mode and trip-state types for the trip latch
package instrumentation_pkg;

  localparam int NChannels   = 3;
  localparam int Log2Modes   = 2;
  localparam int DebounceMax = 15;
  localparam int CountWidth  = 4;

  typedef enum logic [Log2Modes-1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_OPERATE  = 2'd1,
    MODE_MANUAL   = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    TRIPPED  = 2'd2
  } trip_state_t;

  // RESERVED is handled exactly like MANUAL so an undefined mode fails safe.
  function automatic logic mode_forces_trip(input mode_t m);
    return (m == MODE_MANUAL) || (m == MODE_RESERVED);
  endfunction

endpackage

// File: rtl/trip_channel_latch.sv
// rtl/trip_channel_latch.sv - one channel: debounce counter, trip FSM and latched trip output
module trip_channel_latch
  import instrumentation_pkg::*;
#(
  parameter int Debounce = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic                  sensor_trip,
  input  mode_t                 mode,
  input  logic                  reset_req,
  output logic                  trip_out,
  output logic [CountWidth-1:0] trip_count
);

  localparam logic [CountWidth-1:0] Limit = CountWidth'(Debounce);

  trip_state_t state;
  logic        qualifying;
  logic        clearing;

  assign qualifying = sample_valid & sensor_trip;
  assign clearing   = sample_valid & ~sensor_trip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trip_count <= '0;
      trip_out   <= 1'b0;
    end else if (mode == MODE_BYPASS) begin
      state      <= IDLE;
      trip_count <= '0;
      trip_out   <= 1'b0;
    end else if (mode_forces_trip(mode)) begin
      // Counter is left alone: a forced trip is not a sensor sample.
      state    <= TRIPPED;
      trip_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (qualifying) begin
            trip_count <= CountWidth'(1);
            if (Limit == CountWidth'(1)) begin
              state    <= TRIPPED;
              trip_out <= 1'b1;
            end else begin
              state <= COUNTING;
            end
          end
        end
        COUNTING: begin
          if (qualifying) begin
            trip_count <= trip_count + CountWidth'(1);
            if (trip_count + CountWidth'(1) >= Limit) begin
              state    <= TRIPPED;
              trip_out <= 1'b1;
            end
          end else if (clearing) begin
            trip_count <= '0;
            state      <= IDLE;
          end
        end
        TRIPPED: begin
          // A qualifying sample beats an operator reset in the same cycle.
          if (qualifying) begin
            if (trip_count < Limit) begin
              trip_count <= trip_count + CountWidth'(1);
            end
          end else if (reset_req && (trip_count == '0)) begin
            state    <= IDLE;
            trip_out <= 1'b0;
          end else if (clearing) begin
            trip_count <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          trip_count <= '0;
          trip_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instrumentation_trip_latch.sv
// rtl/instrumentation_trip_latch.sv - per-channel debounced trip latches for one division
// Optional first-out capture is enabled by defining INSTR_FIRST_OUT_EN.
module instrumentation_trip_latch
  import instrumentation_pkg::*;
#(
  parameter int Debounce = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic [NChannels-1:0]           sensor_trip,
  input  logic [NChannels*Log2Modes-1:0] mode,
  input  logic [NChannels-1:0]           reset_req,
  output logic [NChannels-1:0]           trip_out,
  output logic [NChannels*CountWidth-1:0] trip_count
`ifdef INSTR_FIRST_OUT_EN
  ,
  output logic [NChannels-1:0]           first_out
`endif
);

  // Out-of-range settings are clamped so the 4-bit counter can never wrap.
  localparam int DebounceEff = (Debounce < 1) ? 1 :
                               (Debounce > DebounceMax) ? DebounceMax : Debounce;

  for (genvar ch = 0; ch < NChannels; ch++) begin : g_channel
    trip_channel_latch #(
      .Debounce(DebounceEff)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .sample_valid(sample_valid),
      .sensor_trip (sensor_trip[ch]),
      .mode        (mode_t'(mode[ch*Log2Modes +: Log2Modes])),
      .reset_req   (reset_req[ch]),
      .trip_out    (trip_out[ch]),
      .trip_count  (trip_count[ch*CountWidth +: CountWidth])
    );
  end

`ifdef INSTR_FIRST_OUT_EN
  logic [NChannels-1:0] trip_prev;

  // Captures the riser set one cycle after the first rise from all-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trip_prev <= '0;
      first_out <= '0;
    end else begin
      trip_prev <= trip_out;
      if (trip_out == '0) begin
        first_out <= '0;
      end else if (trip_prev == '0) begin
        first_out <= trip_out;
      end
    end
  end
`endif

endmodule

// File: doc/instrumentation_trip_latch.md
Name: instrumentation_trip_latch

Overview:
- Downstream stage of the sensor-trip comparator in each instrumentation division.
- Consumes the per-channel raw trip bits (value vs. setpoint) and the per-channel maintenance mode.
- Debounces each channel over N consecutive valid samples, then latches the trip until an operator reset is accepted.
- Drives the registered trip vector to the actuation voting logic.

Parameters:
- NChannels, 3, number of sensor channels (fixed by the package constant).
- Log2Modes, 2, width of one channel's mode field.
- Debounce, 3, consecutive tripping samples required to latch; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sample_valid  input  1  sensor_trip holds a fresh comparator result this cycle
- sensor_trip  input  NChannels  raw trip bits; bit ch = channel ch
- mode  input  NChannels*Log2Modes  per-channel mode; channel ch at bits [ch*2+1:ch*2]
- reset_req  input  NChannels  per-channel operator trip-reset request (level)
- trip_out  output  NChannels  latched channel trips to voting logic
- trip_count  output  NChannels*4  per-channel debounce counter (diagnostics)

Behaviour:
- Reset:
  - Async assert clears everything: trip_out=0, all counters 0, first_out=0.
  - Release is synchronous to clk.
- Mode encoding:
  - 0 BYPASS: channel excluded.
  - 1 OPERATE: channel follows sensor_trip.
  - 2 MANUAL_TRIP: channel forced tripped.
  - 3 RESERVED: treated as MANUAL_TRIP (fail-safe).
- Per-channel state machine, states IDLE / COUNTING / TRIPPED:
  - IDLE, counter=0:
    - OPERATE + sample_valid + sensor_trip=1 → counter=1.
    - If Debounce=1, go directly to TRIPPED.
  - COUNTING:
    - OPERATE + sample_valid + trip=1: counter++; on reaching Debounce → TRIPPED.
    - sample_valid + trip=0: counter=0 → IDLE.
    - No sample_valid: hold state and counter.
  - TRIPPED:
    - trip_out=1. Counter saturates at Debounce while trips continue and drops to 0 on the first non-tripping valid sample.
    - Exit to IDLE only when reset_req=1, mode is OPERATE, and counter=0.
  - Any state with mode MANUAL_TRIP/RESERVED: → TRIPPED next edge, independent of sample_valid.
  - Any state with mode BYPASS: → IDLE, counter=0, trip_out=0 next edge. Bypass overrides the latch.
- Latency:
  - trip_out rises on the clock edge after the cycle carrying the Debounce-th consecutive qualifying sample (1 cycle registered).
  - Reset clears trip_out on the edge after the accepted reset_req.
- Simultaneous events:
  - reset_req in the same cycle as a qualifying sample → trip wins; latch held, counter advances.
  - reset_req while counter≠0 or mode is manual → ignored; not remembered.
  - A mode change and a sample in the same cycle use the new mode.
- Counter width: 4 bits, unsigned, never wraps.
- Channels are fully independent; no cross-channel interaction except first_out.

Optional Feature:
- Macro: INSTR_FIRST_OUT_EN.
- Defined: adds output first_out[NChannels-1:0].
  - Captures the channel(s) whose trip_out rose in the earliest cycle in which any rose from an all-clear state. Simultaneous risers are all set.
  - Sticky until every trip_out is 0, then clears the next edge. Reset value 0.
- Not defined: port absent, no first-out logic.

Decomposition:
- Package instrumentation_pkg holds:
  - NChannels, Log2Modes, DebounceMax=15.
  - Mode enum: MODE_BYPASS=0, MODE_OPERATE=1, MODE_MANUAL=2, MODE_RESERVED=3.
  - trip_state_t enum: IDLE / COUNTING / TRIPPED.
- Sub-module trip_channel_latch: one channel's FSM, counter and latch.
  - Top level generates NChannels instances and holds the optional first_out logic.

Test Plan:
- Debounce=3, ch0 OPERATE, trip=1 on 3 consecutive valid samples → trip_out[0]=1 one cycle after the 3rd; trip_count[3:0]=3.
- Trip=1,1,0,1,1 valid samples on ch1 → counter resets on the 0; no trip_out[1].
- ch2 latched, sensor_trip[2]=0 sample then reset_req[2]=1 → trip_out[2]=0 next edge. Same reset_req while trip still 1 → trip_out[2] stays 1.
- ch0 mode=2 with sample_valid=0 → trip_out[0]=1 next edge; mode=3 likewise. Mode→0 → trip_out[0]=0 next edge.
- reset_req[1]=1 in the same cycle as a qualifying sample → trip_out[1] remains 1.
- Assert rst asynchronously mid-count with ch1 latched → trip_out=0, counters 0 immediately. With INSTR_FIRST_OUT_EN, ch0 then ch1 trip → first_out=3'b001, cleared after all reset.
